wb_sel_stage: RTL and testbench

- Registered, parametrised writeback stage between MEM and the register file.
- Selects the writeback source (ALU, RS, RAM, HI, LO, PC+offset, CP0), suppresses writes on exception/interrupt flush, and holds the pipeline while load data is outstanding.
- Drives the register-file write port and a forwarding bus for the decode stage.

---
 rtl/wb_sel_stage.sv | 140 ++++++++++++++
 tb/tb_wb_sel_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sel_stage.sv
// Writeback stage: picks the register-file write source, drops killed instructions,
// and stalls on outstanding load data while exposing the pending destination for forwarding.
module wb_sel_stage #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int PC_OFF   = 8,
  parameter int LOAD_TMO = 15
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      rf_wsel,
  input  logic            mem_rf_nwe,
  input  logic [AW-1:0]   rf_waddr_in,
  input  logic            mem_cp0_ex,
  input  logic            int_flush,
  input  logic [DW-1:0]   pc,
  input  logic [DW-1:0]   alu_in,
  input  logic [DW-1:0]   rs_in,
  input  logic [DW-1:0]   cp0_in,
  input  logic [2*DW-1:0] hilo_in,
  input  logic [DW-1:0]   ram_in,
  input  logic            ram_valid,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [DW-1:0]   rf_wdata,
  output logic            fwd_valid,
  output logic [AW-1:0]   fwd_addr,
  output logic            load_err
);

  localparam int CW = $clog2(LOAD_TMO + 1);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [AW-1:0] load_addr, load_addr_next;
  logic          rf_we_next, fwd_valid_next, load_err_next;
  logic [AW-1:0] rf_waddr_next, fwd_addr_next;
  logic [DW-1:0] rf_wdata_next;
  logic [DW-1:0] src, pc8;
  logic          eff, is_ram;

  assign pc8      = pc + DW'(PC_OFF);
  assign is_ram   = (rf_wsel == 3'b011);
  assign in_ready = (state == IDLE);
  // Register 0 and "no source" are folded into the write-effective test so nothing downstream sees them.
  assign eff = in_valid && !(mem_cp0_ex || int_flush) && mem_rf_nwe &&
               (rf_wsel != 3'b000) && (rf_waddr_in != '0);

  always_comb begin
    src = '0;
    case (rf_wsel)
      3'b001:  src = alu_in;
      3'b010:  src = rs_in;
      3'b011:  src = ram_in;
      3'b100:  src = hilo_in[2*DW-1:DW];
      3'b101:  src = hilo_in[DW-1:0];
      3'b110:  src = pc8;
      3'b111:  src = cp0_in;
      default: src = '0;
    endcase
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    load_addr_next = load_addr;
    rf_we_next     = 1'b0;
    rf_waddr_next  = '0;
    rf_wdata_next  = '0;
    fwd_valid_next = 1'b0;
    fwd_addr_next  = '0;
    load_err_next  = load_err;
    case (state)
      IDLE: begin
        if (eff) begin
          fwd_valid_next = 1'b1;
          fwd_addr_next  = rf_waddr_in;
          if (is_ram && !ram_valid) begin
            state_next     = WAIT_LOAD;
            cnt_next       = '0;
            load_addr_next = rf_waddr_in;
          end else begin
            rf_we_next    = 1'b1;
            rf_waddr_next = rf_waddr_in;
            rf_wdata_next = src;
          end
        end
      end
      WAIT_LOAD: begin
        if (int_flush) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (ram_valid) begin
          state_next     = IDLE;
          cnt_next       = '0;
          rf_we_next     = 1'b1;
          rf_waddr_next  = load_addr;
          rf_wdata_next  = ram_in;
          fwd_valid_next = 1'b1;
          fwd_addr_next  = load_addr;
        end else begin
          fwd_valid_next = 1'b1;
          fwd_addr_next  = load_addr;
          if (cnt != CW'(LOAD_TMO)) cnt_next = cnt + 1'b1;
          if (cnt_next == CW'(LOAD_TMO)) load_err_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      load_addr <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      fwd_valid <= 1'b0;
      fwd_addr  <= '0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      load_addr <= load_addr_next;
      rf_we     <= rf_we_next;
      rf_waddr  <= rf_waddr_next;
      rf_wdata  <= rf_wdata_next;
      fwd_valid <= fwd_valid_next;
      fwd_addr  <= fwd_addr_next;
      load_err  <= load_err_next;
    end
  end

endmodule

// File: tb/tb_wb_sel_stage.sv
// Bench for wb_sel_stage: directed vectors with literal expectations plus a
// transaction-level reference model compared on every clock.
module tb_wb_sel_stage;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [2:0]  rf_wsel = 3'd0;
  logic        mem_rf_nwe = 1'b0;
  logic [4:0]  rf_waddr_in = 5'd0;
  logic        mem_cp0_ex = 1'b0, int_flush = 1'b0;
  logic [31:0] pc = 32'd0, alu_in = 32'd0, rs_in = 32'd0, cp0_in = 32'd0, ram_in = 32'd0;
  logic [63:0] hilo_in = 64'd0;
  logic        ram_valid = 1'b0;
  logic        rf_we, fwd_valid, load_err;
  logic [4:0]  rf_waddr, fwd_addr;
  logic [31:0] rf_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  wb_sel_stage #(.DW(32), .AW(5), .PC_OFF(8), .LOAD_TMO(15)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .rf_wsel(rf_wsel), .mem_rf_nwe(mem_rf_nwe), .rf_waddr_in(rf_waddr_in),
    .mem_cp0_ex(mem_cp0_ex), .int_flush(int_flush), .pc(pc), .alu_in(alu_in),
    .rs_in(rs_in), .cp0_in(cp0_in), .hilo_in(hilo_in), .ram_in(ram_in),
    .ram_valid(ram_valid), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: "waiting" means a load is outstanding for m_addr; m_waits counts
  // wait cycles with no data, and the error flag latches once that reaches the timeout.
  bit          m_waiting = 0;
  int          m_waits = 0;
  logic [4:0]  m_addr = 0;
  bit          m_err = 0;
  logic        m_we = 0, m_fv = 0;
  logic [4:0]  m_waddr = 0, m_fa = 0;
  logic [31:0] m_wdata = 0;
  logic [32:0] m_sum;
  logic [31:0] m_src;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_waiting = 0; m_waits = 0; m_addr = 0; m_err = 0;
      m_we = 0; m_fv = 0; m_waddr = 0; m_fa = 0; m_wdata = 0;
    end else begin
      m_we = 0; m_fv = 0; m_waddr = 0; m_fa = 0; m_wdata = 0;
      if (!m_waiting) begin
        if (in_valid && !mem_cp0_ex && !int_flush && mem_rf_nwe && rf_wsel != 0 && rf_waddr_in != 0) begin
          m_sum = {1'b0, pc} + 33'd8;
          case (rf_wsel)
            3'd1: m_src = alu_in;
            3'd2: m_src = rs_in;
            3'd3: m_src = ram_in;
            3'd4: m_src = hilo_in[63:32];
            3'd5: m_src = hilo_in[31:0];
            3'd6: m_src = m_sum[31:0];
            default: m_src = cp0_in;
          endcase
          m_fv = 1; m_fa = rf_waddr_in;
          if (rf_wsel == 3'd3 && !ram_valid) begin
            m_waiting = 1; m_waits = 0; m_addr = rf_waddr_in;
          end else begin
            m_we = 1; m_waddr = rf_waddr_in; m_wdata = m_src;
          end
        end
      end else if (int_flush) begin
        m_waiting = 0;
      end else if (ram_valid) begin
        m_waiting = 0;
        m_we = 1; m_waddr = m_addr; m_wdata = ram_in; m_fv = 1; m_fa = m_addr;
      end else begin
        m_waits++;
        if (m_waits >= 15) m_err = 1;
        m_fv = 1; m_fa = m_addr;
      end
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      check("cyc_rf_we", rf_we, m_we);
      check("cyc_rf_waddr", rf_waddr, m_waddr);
      check("cyc_rf_wdata", rf_wdata, m_wdata);
      check("cyc_fwd_valid", fwd_valid, m_fv);
      check("cyc_fwd_addr", fwd_addr, m_fa);
      check("cyc_load_err", load_err, m_err);
      check("cyc_in_ready", in_ready, !m_waiting);
    end
  end

  // Present control inputs for one rising edge, return 1 time unit after it.
  task automatic drive(input logic v, input logic [2:0] ws, input logic nwe, input logic [4:0] wa,
                       input logic ex, input logic fl, input logic rv);
    in_valid = v; rf_wsel = ws; mem_rf_nwe = nwe; rf_waddr_in = wa;
    mem_cp0_ex = ex; int_flush = fl; ram_valid = rv;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 3'd0, 0, 5'd0, 0, 0, 0);
  endtask

  initial begin
    #12;
    check("reset_rf_we", rf_we, 0);
    check("reset_rf_wdata", rf_wdata, 0);
    check("reset_fwd_valid", fwd_valid, 0);
    check("reset_load_err", load_err, 0);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk); #1; resetn = 1'b1;

    alu_in = 32'h1234;
    drive(1, 3'd1, 1, 5'd3, 0, 0, 0);
    check("alu_we", rf_we, 1);
    check("alu_waddr", rf_waddr, 5'd3);
    check("alu_wdata", rf_wdata, 32'h1234);
    idle(1);
    check("alu_pulse", rf_we, 0);

    hilo_in = 64'hAAAA0000_00005555; pc = 32'hFFFFFFFC;
    rs_in = 32'h0BAD_F00D; cp0_in = 32'hC0C0_0001;
    drive(1, 3'd4, 1, 5'd9, 0, 0, 0);
    check("hi_wdata", rf_wdata, 32'hAAAA0000);
    drive(1, 3'd5, 1, 5'd10, 0, 0, 0);
    check("lo_wdata", rf_wdata, 32'h00005555);
    drive(1, 3'd6, 1, 5'd31, 0, 0, 0);
    check("pc8_wrap", rf_wdata, 32'h00000004);
    drive(1, 3'd2, 1, 5'd11, 0, 0, 0);
    check("rs_wdata", rf_wdata, 32'h0BADF00D);
    drive(1, 3'd7, 1, 5'd12, 0, 0, 0);
    check("cp0_wdata", rf_wdata, 32'hC0C00001);

    ram_in = 32'h0;
    drive(1, 3'd3, 1, 5'd7, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check("ld_in_ready", in_ready, 0);
      check("ld_fwd_valid", fwd_valid, 1);
      check("ld_fwd_addr", fwd_addr, 5'd7);
      check("ld_no_we", rf_we, 0);
      drive(1, 3'd1, 1, 5'd20, 0, 0, 0);
    end
    ram_in = 32'hDEADBEEF;
    drive(1, 3'd1, 1, 5'd21, 0, 0, 1);
    check("ld_we", rf_we, 1);
    check("ld_waddr", rf_waddr, 5'd7);
    check("ld_wdata", rf_wdata, 32'hDEADBEEF);
    check("ld_ready_after", in_ready, 1);
    idle(1);
    check("ld_pulse", rf_we, 0);

    ram_in = 32'h55;
    drive(1, 3'd3, 1, 5'd2, 0, 0, 1);
    check("ram_now_we", rf_we, 1);
    check("ram_now_wdata", rf_wdata, 32'h55);

    drive(1, 3'd1, 1, 5'd5, 1, 0, 0);
    check("kill_ex_we", rf_we, 0);
    check("kill_ex_fwd", fwd_valid, 0);
    drive(1, 3'd1, 1, 5'd5, 0, 1, 0);
    check("kill_int_we", rf_we, 0);
    drive(1, 3'd3, 1, 5'd8, 0, 0, 0);
    idle(1);
    drive(0, 3'd0, 0, 5'd0, 0, 1, 1);
    check("flush_wait_we", rf_we, 0);
    check("flush_wait_fwd", fwd_valid, 0);
    check("flush_wait_ready", in_ready, 1);

    drive(1, 3'd1, 1, 5'd0, 0, 0, 0);
    check("reg0_we", rf_we, 0);
    check("reg0_fwd", fwd_valid, 0);
    drive(1, 3'd0, 1, 5'd4, 0, 0, 0);
    check("none_we", rf_we, 0);
    check("none_fwd", fwd_valid, 0);
    drive(1, 3'd3, 0, 5'd4, 0, 0, 0);
    check("ram_nwe0_ready", in_ready, 1);

    drive(1, 3'd3, 1, 5'd12, 0, 0, 0);
    idle(14);
    check("tmo_err_before", load_err, 0);
    idle(1);
    check("tmo_err_at", load_err, 1);
    idle(5);
    check("tmo_err_sticky", load_err, 1);
    check("tmo_still_wait", in_ready, 0);
    #2 resetn = 1'b0;
    #1;
    check("rst_fwd", fwd_valid, 0);
    check("rst_fwd_addr", fwd_addr, 0);
    check("rst_err", load_err, 0);
    check("rst_we", rf_we, 0);
    @(posedge clk); #1; resetn = 1'b1;
    check("rst_ready", in_ready, 1);
    alu_in = 32'h600D;
    drive(1, 3'd1, 1, 5'd6, 0, 0, 0);
    check("post_rst_wdata", rf_wdata, 32'h600D);

    for (int i = 0; i < 300; i++) begin
      alu_in = $urandom; rs_in = $urandom; cp0_in = $urandom; ram_in = $urandom;
      pc = $urandom; hilo_in = {$urandom, $urandom};
      drive(($urandom % 4) != 0, 3'($urandom % 8), ($urandom % 4) != 0, 5'($urandom % 8),
            ($urandom % 8) == 0, ($urandom % 10) == 0, ($urandom % 2) == 1);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
